// File: rtl/nonlinear_pipe_if.sv
// rtl/nonlinear_pipe_if.sv - block handshake bundle between a 3-Way round stage and nonlinear_pipe
interface nonlinear_pipe_if #(
  parameter int WORD_W = 32
);
  logic [3*WORD_W-1:0] iword;
  logic                imu;
  logic                ivalid;
  logic                iready;
  logic [3*WORD_W-1:0] oword;
  logic                ovalid;
  logic                oready;
  logic [15:0]         ocount;

  modport master (
    output iword, imu, ivalid, oready,
    input  iready, oword, ovalid, ocount
  );

  modport slave (
    input  iword, imu, ivalid, oready,
    output iready, oword, ovalid, ocount
  );
endinterface

// File: rtl/nonlinear_pipe.sv
// rtl/nonlinear_pipe.sv - 3-Way gamma step into a bubble-collapsing STAGES-deep pipeline
// Optional mu pre-permutation for the decryption path: define NONLINEAR_MU_EN.
module nonlinear_pipe #(
  parameter int WORD_W = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  nonlinear_pipe_if.slave blk
);
  localparam int BW = 3 * WORD_W;

  logic [WORD_W-1:0] in_a0, in_a1, in_a2;
  logic [WORD_W-1:0] a0, a1, a2;
  logic [BW-1:0]     gamma_w;

  logic [BW-1:0]     data_q [STAGES];
  logic [BW-1:0]     data_d [STAGES];
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] load;
  logic [15:0]       ocount_q, ocount_d;
  logic              out_xfer;

  assign in_a0 = blk.iword[WORD_W-1:0];
  assign in_a1 = blk.iword[2*WORD_W-1:WORD_W];
  assign in_a2 = blk.iword[3*WORD_W-1:2*WORD_W];

`ifdef NONLINEAR_MU_EN
  function automatic logic [WORD_W-1:0] bitrev(input logic [WORD_W-1:0] x);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[i] = x[WORD_W-1-i];
    return r;
  endfunction

  always_comb begin
    a0 = in_a0;
    a1 = in_a1;
    a2 = in_a2;
    if (blk.imu) begin
      a0 = bitrev(in_a2);
      a1 = bitrev(in_a1);
      a2 = bitrev(in_a0);
    end
  end
`else
  logic unused_imu;
  assign unused_imu = blk.imu;
  assign a0 = in_a0;
  assign a1 = in_a1;
  assign a2 = in_a2;
`endif

  assign gamma_w = {a2 ^ (a0 | ~a1), a1 ^ (a2 | ~a0), a0 ^ (a1 | ~a2)};

  // A stage can load when empty or when everything downstream of it moves this cycle.
  always_comb begin
    logic go;
    go = ~vld_q[STAGES-1] | blk.oready;
    load[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go = ~vld_q[k] | go;
      load[k] = go;
    end
  end

  assign out_xfer = vld_q[STAGES-1] & blk.oready;

  always_comb begin
    vld_d     = vld_q;
    data_d[0] = data_q[0];
    if (load[0]) begin
      vld_d[0] = blk.ivalid;
      if (blk.ivalid) data_d[0] = gamma_w;
    end
    // Data only moves with a valid flag so an empty last stage keeps showing its last block.
    for (int k = 1; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  assign ocount_d = ocount_q + {15'd0, out_xfer};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      ocount_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      vld_q    <= vld_d;
      ocount_q <= ocount_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign blk.iready = load[0];
  assign blk.ovalid = vld_q[STAGES-1];
  assign blk.oword  = data_q[STAGES-1];
  assign blk.ocount = ocount_q;
endmodule
